cipher_job_bridge: RTL and testbench

- Avalon-MM slave that replaces the discrete per-word PIO bundle (key, block, out, start, busy, ende, core reset) between the NIOS CPU and the block-cipher core.
- Generalised in key width, block width and queue depth.
- Queues up to DEPTH encrypt/decrypt jobs, issues them to the core with a start/busy handshake, and buffers results with an interrupt.
- Sits between the Platform Designer fabric and the cipher core.

---
 rtl/cipher_job_bridge_if.sv | 39 +++
 rtl/cipher_job_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_cipher_job_bridge.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_job_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : cipher_job_bridge_if
// Description : Avalon-MM slave bus plus cipher-core handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cipher_job_bridge_if #(
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 256
);
    logic [5:0]         avs_address;
    logic               avs_read;
    logic               avs_write;
    logic [31:0]        avs_writedata;
    logic [31:0]        avs_readdata;
    logic               irq;
    logic [KEY_W-1:0]   core_key;
    logic [BLOCK_W-1:0] core_block;
    logic               core_ende;
    logic               core_start;
    logic               core_reset;
    logic               core_busy;
    logic [BLOCK_W-1:0] core_out;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq,
        output core_key, core_block, core_ende, core_start, core_reset,
        input  core_busy, core_out
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq,
        input  core_key, core_block, core_ende, core_start, core_reset,
        output core_busy, core_out
    );
endinterface
`default_nettype wire

// File: rtl/cipher_job_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cipher_job_bridge
// Description : Avalon-MM job queue that feeds a block-cipher core and
//               buffers its results behind a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_job_bridge #(
    parameter int BLOCK_W  = 128,
    parameter int KEY_W    = 256,
    parameter int DEPTH    = 4,
    parameter int START_TO = 15
) (
    input  wire                clk_clk,
    input  wire                reset_reset,
    cipher_job_bridge_if.slave bus
);
    localparam int c_KEY_WORDS = KEY_W / 32;
    localparam int c_BLK_WORDS = BLOCK_W / 32;
    localparam int c_PTR_W     = $clog2(DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_TO_W      = $clog2(START_TO + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(START_TO - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAITB = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [KEY_W-1:0]    r_key;
    logic [BLOCK_W-1:0]  r_blk;
    logic [BLOCK_W:0]    r_job_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_job_wp, r_job_rp;
    logic [c_CNT_W-1:0]  r_job_cnt;
    logic [BLOCK_W-1:0]  r_res_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_res_wp, r_res_rp;
    logic [c_CNT_W-1:0]  r_res_cnt;
    logic [BLOCK_W-1:0]  r_core_block;
    logic                r_core_ende;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_discard;
    logic                r_ovf, r_unf, r_keyerr, r_timeout;
    logic                r_irq_en, r_irq;
    logic [31:0]         r_readdata;
    logic                r_core_rst;

    logic [1:0]          w_page;
    logic [3:0]          w_idx;
    logic                w_key_wr, w_blk_wr, w_ctrl_wr, w_stat_wr, w_irqen_wr;
    logic                w_push, w_pop, w_flush;
    logic                w_push_ok, w_pop_ok, w_ovf_evt, w_unf_evt, w_keyerr_evt;
    logic                w_deq, w_res_enq, w_to_hit;
    logic [BLOCK_W:0]    w_job_head;
    logic [BLOCK_W-1:0]  w_res_head;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;

    assign w_page     = bus.avs_address[5:4];
    assign w_idx      = bus.avs_address[3:0];
    assign w_key_wr   = bus.avs_write && (w_page == 2'd0);
    assign w_blk_wr   = bus.avs_write && (w_page == 2'd1);
    assign w_ctrl_wr  = bus.avs_write && (bus.avs_address == 6'h30);
    assign w_stat_wr  = bus.avs_write && (bus.avs_address == 6'h31);
    assign w_irqen_wr = bus.avs_write && (bus.avs_address == 6'h32);

    assign w_push  = w_ctrl_wr && bus.avs_writedata[0];
    assign w_pop   = w_ctrl_wr && bus.avs_writedata[2];
    assign w_flush = w_ctrl_wr && bus.avs_writedata[3];

    // A full FIFO still accepts a push when the dispatcher frees a slot in the same cycle.
    assign w_push_ok    = w_push && !w_flush && ((r_job_cnt != c_DEPTH_CNT) || w_deq);
    assign w_ovf_evt    = w_push && !w_flush && !w_push_ok;
    assign w_pop_ok     = w_pop && !w_flush && (r_res_cnt != '0);
    assign w_unf_evt    = w_pop && !w_flush && (r_res_cnt == '0);
    assign w_keyerr_evt = w_key_wr && (r_state != c_IDLE);

    assign w_job_head = r_job_mem[r_job_rp];
    assign w_res_head = r_res_mem[r_res_rp];

    assign w_status = {11'd0, r_timeout, r_keyerr, r_unf, r_ovf, (r_state != c_IDLE),
                       8'(r_res_cnt), 8'(r_job_cnt)};

    assign bus.avs_readdata = r_readdata;
    assign bus.irq          = r_irq;
    assign bus.core_key     = r_key;
    assign bus.core_block   = r_core_block;
    assign bus.core_ende    = r_core_ende;
    assign bus.core_start   = (r_state == c_ISSUE);
    assign bus.core_reset   = reset_reset || r_core_rst;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= c_IDLE;
        else             r_state <= w_state_nxt;
    end

    // The head is latched and dequeued on entry to ISSUE so block/ende are valid with core_start.
    always_comb begin
        w_state_nxt = r_state;
        w_deq       = 1'b0;
        w_res_enq   = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if ((r_job_cnt != '0) && (r_res_cnt < c_DEPTH_CNT) && !bus.core_busy && !w_flush) begin
                    w_state_nxt = c_ISSUE;
                    w_deq       = 1'b1;
                end
            end
            c_ISSUE: w_state_nxt = c_WAITB;
            c_WAITB: begin
                if (bus.core_busy) begin
                    w_state_nxt = c_RUN;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            c_RUN: begin
                if (!bus.core_busy) begin
                    w_res_enq   = !r_discard && !w_flush;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_page)
            2'd0: begin
                for (int i = 0; i < c_KEY_WORDS; i++)
                    if (w_idx == 4'(i)) w_rdata = r_key[i*32 +: 32];
            end
            2'd1: begin
                for (int i = 0; i < c_BLK_WORDS; i++)
                    if (w_idx == 4'(i)) w_rdata = r_blk[i*32 +: 32];
            end
            2'd2: begin
                if (r_res_cnt != '0)
                    for (int i = 0; i < c_BLK_WORDS; i++)
                        if (w_idx == 4'(i)) w_rdata = w_res_head[i*32 +: 32];
            end
            default: begin
                if (w_idx == 4'd1)      w_rdata = w_status;
                else if (w_idx == 4'd2) w_rdata = {31'd0, r_irq_en};
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_key        <= '0;
            r_blk        <= '0;
            r_job_wp     <= '0;
            r_job_rp     <= '0;
            r_job_cnt    <= '0;
            r_res_wp     <= '0;
            r_res_rp     <= '0;
            r_res_cnt    <= '0;
            r_core_block <= '0;
            r_core_ende  <= 1'b0;
            r_to_cnt     <= '0;
            r_discard    <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_keyerr     <= 1'b0;
            r_timeout    <= 1'b0;
            r_irq_en     <= 1'b0;
            r_irq        <= 1'b0;
            r_readdata   <= '0;
            r_core_rst   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_job_mem[i] <= '0;
                r_res_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_KEY_WORDS; i++)
                if (w_key_wr && (r_state == c_IDLE) && (w_idx == 4'(i)))
                    r_key[i*32 +: 32] <= bus.avs_writedata;
            for (int i = 0; i < c_BLK_WORDS; i++)
                if (w_blk_wr && (w_idx == 4'(i)))
                    r_blk[i*32 +: 32] <= bus.avs_writedata;

            if (w_flush) begin
                r_job_wp  <= '0;
                r_job_rp  <= '0;
                r_job_cnt <= '0;
            end else begin
                if (w_push_ok) begin
                    r_job_mem[r_job_wp] <= {bus.avs_writedata[1], r_blk};
                    r_job_wp            <= r_job_wp + c_PTR_ONE;
                end
                if (w_deq) r_job_rp <= r_job_rp + c_PTR_ONE;
                r_job_cnt <= r_job_cnt + c_CNT_W'(w_push_ok) - c_CNT_W'(w_deq);
            end

            if (w_flush) begin
                r_res_wp  <= '0;
                r_res_rp  <= '0;
                r_res_cnt <= '0;
            end else begin
                if (w_res_enq) begin
                    r_res_mem[r_res_wp] <= bus.core_out;
                    r_res_wp            <= r_res_wp + c_PTR_ONE;
                end
                if (w_pop_ok) r_res_rp <= r_res_rp + c_PTR_ONE;
                r_res_cnt <= r_res_cnt + c_CNT_W'(w_res_enq) - c_CNT_W'(w_pop_ok);
            end

            if (w_deq) begin
                r_core_block <= w_job_head[BLOCK_W-1:0];
                r_core_ende  <= w_job_head[BLOCK_W];
            end

            if (r_state == c_WAITB) r_to_cnt <= r_to_cnt + c_TO_W'(1);
            else                    r_to_cnt <= '0;

            // A flushed in-flight job must not land in the freshly emptied result FIFO.
            if (r_state == c_IDLE) r_discard <= 1'b0;
            else if (w_flush)      r_discard <= 1'b1;

            r_ovf     <= (r_ovf     && !w_stat_wr) || w_ovf_evt;
            r_unf     <= (r_unf     && !w_stat_wr) || w_unf_evt;
            r_keyerr  <= (r_keyerr  && !w_stat_wr) || w_keyerr_evt;
            r_timeout <= (r_timeout && !w_stat_wr) || w_to_hit;

            if (w_irqen_wr) r_irq_en <= bus.avs_writedata[0];
            r_irq      <= r_irq_en && (r_res_cnt != '0);
            r_core_rst <= w_ctrl_wr && bus.avs_writedata[4];

            if (bus.avs_read) r_readdata <= w_rdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cipher_job_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cipher_job_bridge
// Description : Directed self-checking bench for cipher_job_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cipher_job_bridge;
    logic         clk;
    logic         rst;
    logic         ext_busy;
    logic         m_busy;
    logic [127:0] m_out;
    logic [127:0] m_blk;
    logic         m_ende;
    int           core_lat;
    logic         core_mute;
    int           n_starts;
    int           n_falls;
    int           n_checks;
    int           n_errors;
    logic [31:0]  key_tbl [8];
    logic [31:0]  res1_tbl [4];
    logic [31:0]  job_tbl [4];

    cipher_job_bridge_if #(.BLOCK_W(128), .KEY_W(256)) bus ();

    assign bus.core_busy = m_busy | ext_busy;
    assign bus.core_out  = m_out;

    cipher_job_bridge #(
        .BLOCK_W (128),
        .KEY_W   (256),
        .DEPTH   (4),
        .START_TO(15)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        n_starts = 0;
        forever begin
            @(negedge clk);
            if (bus.core_start) n_starts++;
        end
    end

    // Core model: busy for core_lat cycles, result is the inverted block.
    initial begin
        m_busy  = 1'b0;
        m_out   = '0;
        m_blk   = '0;
        m_ende  = 1'b0;
        n_falls = 0;
        forever begin
            @(negedge clk);
            if (bus.core_start) begin
                m_blk  = bus.core_block;
                m_ende = bus.core_ende;
                if (!core_mute) begin
                    @(posedge clk);
                    #1 m_busy = 1'b1;
                    repeat (core_lat) @(posedge clk);
                    #1;
                    m_out  = ~m_blk;
                    m_busy = 1'b0;
                    n_falls++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 50 && !bus.core_busy; k++) @(negedge clk);
        chk("core_busy_seen", 32'(bus.core_busy), 32'd1);
    endtask

    task automatic wait_fall(input int f0);
        for (int k = 0; k < 100 && n_falls == f0; k++) @(negedge clk);
        chk("core_done_seen", 32'(n_falls != f0), 32'd1);
    endtask

    task automatic wait_rcount(input logic [7:0] n);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 100; k++) begin
            rd(6'h31, s);
            if (s[15:8] == n) break;
        end
        chk("result_count_reached", 32'(s[15:8]), 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        int s0;
        int f0;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        ext_busy = 1'b0;
        core_lat = 16;
        core_mute = 1'b0;
        bus.avs_address = '0;
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        key_tbl  = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                     32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        res1_tbl = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
        job_tbl  = '{32'hFFFFFEFF, 32'hFFFFFEFE, 32'hFFFFFEFD, 32'hFFFFFEFC};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
        chk("rst_core_start", 32'(bus.core_start), 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_readdata", bus.avs_readdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("core_reset_released", 32'(bus.core_reset), 32'd0);
        rd(6'h31, d);
        chk("status_after_reset", d, 32'd0);

        // Single encrypt job
        for (int i = 0; i < 8; i++) wr(6'(i), key_tbl[i]);
        for (int i = 0; i < 4; i++) wr(6'(16 + i), 32'(i));
        for (int i = 0; i < 8; i++) chk("core_key_word", bus.core_key[i*32 +: 32], key_tbl[i]);
        wr(6'h32, 32'd1);
        rd(6'h32, d);
        chk("irq_en_readback", d, 32'd1);
        s0 = n_starts;
        f0 = n_falls;
        wr(6'h30, 32'h3);
        wait_fall(f0);
        chk("irq_before_enqueue", 32'(bus.irq), 32'd0);
        @(negedge clk);
        chk("irq_at_enqueue", 32'(bus.irq), 32'd0);
        @(negedge clk);
        chk("irq_after_enqueue", 32'(bus.irq), 32'd1);
        chk("start_pulses_job1", 32'(n_starts - s0), 32'd1);
        chk("core_ende_job1", 32'(m_ende), 32'd1);
        for (int i = 0; i < 4; i++) chk("core_block_job1", m_blk[i*32 +: 32], 32'(i));
        for (int i = 0; i < 4; i++) begin
            rd(6'(32 + i), d);
            chk("result_word_job1", d, res1_tbl[i]);
        end
        rd(6'h31, d);
        chk("status_one_result", d, 32'h00000100);
        wr(6'h30, 32'h4);
        rd(6'h31, d);
        chk("status_after_pop", d, 32'd0);
        chk("irq_after_pop", 32'(bus.irq), 32'd0);
        rd(6'h20, d);
        chk("result_empty_reads_zero", d, 32'd0);

        // Queue fill and overflow while the core is held busy
        ext_busy = 1'b1;
        core_lat = 3;
        s0 = n_starts;
        for (int j = 0; j < 5; j++) begin
            wr(6'h10, 32'h100 + 32'(j));
            wr(6'h30, (j % 2 == 1) ? 32'h3 : 32'h1);
        end
        rd(6'h31, d);
        chk("status_queue_full_ovf", d, 32'h00020004);
        chk("no_issue_while_busy", 32'(n_starts - s0), 32'd0);
        ext_busy = 1'b0;
        wait_rcount(8'd4);
        rd(6'h31, d);
        chk("status_results_full", d, 32'h00020400);
        for (int j = 0; j < 4; j++) begin
            rd(6'h20, d);
            chk("result_order_w0", d, job_tbl[j]);
            rd(6'h21, d);
            chk("result_order_w1", d, 32'hFFFFFFFE);
            wr(6'h30, 32'h4);
        end
        rd(6'h31, d);
        chk("status_drained", d, 32'h00020000);
        chk("start_pulses_queue", 32'(n_starts - s0), 32'd4);
        wr(6'h30, 32'h4);
        rd(6'h31, d);
        chk("status_pop_empty_unf", d, 32'h00060000);
        wr(6'h31, 32'd0);
        rd(6'h31, d);
        chk("status_sticky_cleared", d, 32'd0);

        // Key write while the core runs
        core_lat = 20;
        wr(6'h10, 32'h55);
        wr(6'h30, 32'h1);
        wait_busy();
        wr(6'h00, 32'hDEADBEEF);
        chk("core_key_protected", bus.core_key[31:0], 32'h00112233);
        rd(6'h00, d);
        chk("key_readback_protected", d, 32'h00112233);
        rd(6'h31, d);
        chk("status_keyerr_run", d, 32'h00090000);
        wait_rcount(8'd1);
        wr(6'h30, 32'h4);
        wr(6'h31, 32'd0);
        rd(6'h31, d);
        chk("status_keyerr_cleared", d, 32'd0);

        // Core never acknowledges
        core_mute = 1'b1;
        s0 = n_starts;
        wr(6'h30, 32'h1);
        repeat (5) @(negedge clk);
        rd(6'h31, d);
        chk("status_waiting_busy", d, 32'h00010000);
        repeat (30) @(negedge clk);
        rd(6'h31, d);
        chk("status_timeout", d, 32'h00100000);
        chk("start_pulses_timeout", 32'(n_starts - s0), 32'd1);
        core_mute = 1'b0;
        wr(6'h31, 32'd0);

        // Flush during RUN
        core_lat = 20;
        s0 = n_starts;
        f0 = n_falls;
        wr(6'h30, 32'h1);
        wr(6'h30, 32'h1);
        wait_busy();
        wr(6'h30, 32'h8);
        rd(6'h31, d);
        chk("status_after_flush", d, 32'h00010000);
        wait_fall(f0);
        repeat (3) @(negedge clk);
        rd(6'h31, d);
        chk("status_flush_result_dropped", d, 32'd0);
        chk("start_pulses_flush", 32'(n_starts - s0), 32'd1);

        // Reset during RUN
        s0 = n_starts;
        f0 = n_falls;
        wr(6'h30, 32'h1);
        wait_busy();
        wr(6'h30, 32'h1);
        rd(6'h31, d);
        chk("status_run_one_queued", d, 32'h00010001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_core_reset", 32'(bus.core_reset), 32'd1);
        chk("midrst_core_start", 32'(bus.core_start), 32'd0);
        chk("midrst_irq", 32'(bus.irq), 32'd0);
        chk("midrst_readdata", bus.avs_readdata, 32'd0);
        chk("midrst_core_key", bus.core_key[31:0], 32'd0);
        chk("midrst_core_block", bus.core_block[31:0], 32'd0);
        chk("midrst_core_ende", 32'(bus.core_ende), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_reset_released", 32'(bus.core_reset), 32'd0);
        wait_fall(f0);
        repeat (3) @(negedge clk);
        rd(6'h31, d);
        chk("status_after_midrst", d, 32'd0);
        rd(6'h00, d);
        chk("key_after_midrst", d, 32'd0);
        rd(6'h32, d);
        chk("irq_en_after_midrst", d, 32'd0);
        chk("start_pulses_midrst", 32'(n_starts - s0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
